// File: rtl/gvt_arbiter_pkg.sv
// Shared swarm definitions: virtual-time word, its maximum value, default array sizing
// and the termination FSM encoding used by the GVT arbiter.
package swarm;

   localparam int N_TILES        = 1;
   localparam int LOG_GVT_PERIOD = 5;
   localparam int TS_WIDTH       = 32;
   localparam int TB_WIDTH       = 32;
   localparam int VT_WIDTH       = TS_WIDTH + TB_WIDTH;
   localparam int C_N_TILES      = 2 ** $clog2(N_TILES);

   typedef struct packed {
      logic [TS_WIDTH-1:0] ts;
      logic [TB_WIDTH-1:0] tb;
   } vt_t;

   localparam vt_t VT_MAX = '1;

   typedef enum logic [1:0] {
      TERM_RUN   = 2'd0,
      TERM_IDLE1 = 2'd1,
      TERM_DONE  = 2'd2
   } term_state_t;

endpackage

// File: rtl/gvt_arbiter_min_tree_stage.sv
// One registered level of the GVT min-reduction tree: pairs of inputs are reduced to
// their unsigned minimum, with a valid bit and the sample's idle flag carried alongside.
module min_tree_stage #(
   parameter int VT_W  = 64,
   parameter int N_OUT = 1
) (
   input  logic                              clk,
   input  logic                              rstn,
   input  logic [2*N_OUT-1:0][VT_W-1:0]      din,
   input  logic                              din_valid,
   input  logic                              din_idle,
   output logic [N_OUT-1:0][VT_W-1:0]        dout,
   output logic                              dout_valid,
   output logic                              dout_idle
);

   logic [N_OUT-1:0][VT_W-1:0] min_next;

   for (genvar g = 0; g < N_OUT; g++) begin : g_pair
      assign min_next[g] = (din[2*g] <= din[2*g+1]) ? din[2*g] : din[2*g+1];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         dout       <= '1;
         dout_valid <= 1'b0;
         dout_idle  <= 1'b0;
      end else begin
         dout       <= min_next;
         dout_valid <= din_valid;
         dout_idle  <= din_idle;
      end
   end

endmodule

// File: rtl/gvt_arbiter.sv
// Periodically samples every tile's LVT, reduces it to a minimum through a pipelined tree,
// publishes a monotonic GVT and detects global termination after two idle periods.
module gvt_arbiter
   import swarm::*;
#(
   parameter int N_TILES        = swarm::N_TILES,
   parameter int LOG_GVT_PERIOD = swarm::LOG_GVT_PERIOD,
   parameter int TS_WIDTH       = swarm::TS_WIDTH,
   parameter int TB_WIDTH       = swarm::TB_WIDTH
) (
   input  logic                                   clk,
   input  logic                                   rstn,
   input  logic [N_TILES*(TS_WIDTH+TB_WIDTH)-1:0] lvt,
   input  logic [N_TILES-1:0]                     lvt_valid,
   input  logic                                   gvt_freeze,
   output logic [TS_WIDTH+TB_WIDTH-1:0]           gvt,
   output logic                                   gvt_valid,
   output logic                                   all_idle,
   output term_state_t                            term_state
);

   localparam int VT_W    = TS_WIDTH + TB_WIDTH;
   localparam int LOG_C   = $clog2(N_TILES);
   localparam int C_N     = 1 << LOG_C;
   localparam int N_NODES = 2 * C_N - 1;

   if ((2 ** LOG_GVT_PERIOD) <= (LOG_C + 2)) begin : g_period_check
      $error("gvt_arbiter: sampling period too short for the reduction pipeline depth");
   end

   logic [LOG_GVT_PERIOD-1:0] period_cnt;
   logic                      strobe;

   assign strobe = (period_cnt == '1) && !gvt_freeze;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         period_cnt <= '0;
      end else if (!gvt_freeze) begin
         period_cnt <= period_cnt + 1'b1;
      end
   end

   // Invalid tiles and pad leaves enter the tree as the maximum VT so they never win.
   logic [C_N-1:0][VT_W-1:0] leaf_next;
   logic [C_N-1:0][VT_W-1:0] samp_data;
   logic                     samp_valid;
   logic                     samp_idle;

   for (genvar t = 0; t < C_N; t++) begin : g_leaf
      if (t < N_TILES) begin : g_real
         assign leaf_next[t] = lvt_valid[t] ? lvt[t*VT_W +: VT_W] : '1;
      end else begin : g_pad
         assign leaf_next[t] = '1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         samp_data  <= '1;
         samp_valid <= 1'b0;
         samp_idle  <= 1'b0;
      end else begin
         samp_valid <= strobe;
         if (strobe) begin
            samp_data <= leaf_next;
            samp_idle <= ~|lvt_valid;
         end
      end
   end

   // Tree nodes stored level after level: leaves first, root last.
   logic [N_NODES-1:0][VT_W-1:0] node;
   logic [LOG_C:0]               lvl_valid;
   logic [LOG_C:0]               lvl_idle;

   assign node[C_N-1:0] = samp_data;
   assign lvl_valid[0]  = samp_valid;
   assign lvl_idle[0]   = samp_idle;

   for (genvar l = 0; l < LOG_C; l++) begin : g_level
      localparam int N_IN    = C_N >> l;
      localparam int N_OUT   = C_N >> (l + 1);
      localparam int OFF_IN  = 2 * C_N - 2 * N_IN;
      localparam int OFF_OUT = 2 * C_N - 2 * N_OUT;

      min_tree_stage #(
         .VT_W  (VT_W),
         .N_OUT (N_OUT)
      ) u_stage (
         .clk        (clk),
         .rstn       (rstn),
         .din        (node[OFF_IN+N_IN-1:OFF_IN]),
         .din_valid  (lvl_valid[l]),
         .din_idle   (lvl_idle[l]),
         .dout       (node[OFF_OUT+N_OUT-1:OFF_OUT]),
         .dout_valid (lvl_valid[l+1]),
         .dout_idle  (lvl_idle[l+1])
      );
   end

   logic [VT_W-1:0] tree_min;
   logic            tree_valid;
   logic            tree_idle;

   assign tree_min   = node[N_NODES-1];
   assign tree_valid = lvl_valid[LOG_C];
   assign tree_idle  = lvl_idle[LOG_C];

   // GVT only moves forward; an all-idle minimum (VT_MAX) carries no time information.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         gvt       <= '0;
         gvt_valid <= 1'b0;
      end else begin
         gvt_valid <= tree_valid;
         if (tree_valid && (tree_min != '1) && (tree_min > gvt)) begin
            gvt <= tree_min;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         term_state <= TERM_RUN;
         all_idle   <= 1'b0;
      end else if (tree_valid) begin
         case (term_state)
            TERM_RUN: begin
               if (tree_idle) term_state <= TERM_IDLE1;
            end
            TERM_IDLE1: begin
               if (tree_idle) begin
                  term_state <= TERM_DONE;
                  all_idle   <= 1'b1;
               end else begin
                  term_state <= TERM_RUN;
               end
            end
            TERM_DONE: begin
               term_state <= TERM_DONE;
               all_idle   <= 1'b1;
            end
            default: begin
               term_state <= TERM_RUN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gvt_arbiter.sv
// Directed and randomized checks of gvt_arbiter (4 tiles, 32-cycle period) against a
// per-cycle reference model of sampling, minimum, monotonic publish and termination.
module tb_gvt_arbiter;

   localparam int N    = 4;
   localparam int LOGP = 5;
   localparam int TSW  = 32;
   localparam int TBW  = 32;
   localparam int VW   = TSW + TBW;
   localparam int PER  = 1 << LOGP;
   localparam int LAT  = 3;

   logic              clk = 1'b0;
   logic              rstn = 1'b0;
   logic [N*VW-1:0]   lvt = '0;
   logic [N-1:0]      lvt_valid = '0;
   logic              gvt_freeze = 1'b0;
   logic [VW-1:0]     gvt;
   logic              gvt_valid;
   logic              all_idle;
   logic [1:0]        term_state;

   gvt_arbiter #(
      .N_TILES        (N),
      .LOG_GVT_PERIOD (LOGP),
      .TS_WIDTH       (TSW),
      .TB_WIDTH       (TBW)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .lvt        (lvt),
      .lvt_valid  (lvt_valid),
      .gvt_freeze (gvt_freeze),
      .gvt        (gvt),
      .gvt_valid  (gvt_valid),
      .all_idle   (all_idle),
      .term_state (term_state)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: phase within the period, pending samples and published state.
   logic [VW:0]   exp_q[$];
   int            due_q[$];
   int            m_phase = 0;
   int            edge_k = 0;
   logic [VW-1:0] m_gvt = '0;
   int            m_streak = 0;
   logic          m_done = 1'b0;
   int            pulses = 0;

   task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_tile(input int t, input logic [TSW-1:0] ts, input logic [TBW-1:0] tb);
      lvt[t*VW +: VW] = {ts, tb};
   endtask

   function automatic logic [VW-1:0] ref_min();
      logic [VW-1:0] m;
      m = '1;
      for (int t = 0; t < N; t++) begin
         if (lvt_valid[t] && lvt[t*VW +: VW] < m) m = lvt[t*VW +: VW];
      end
      return m;
   endfunction

   task automatic tick();
      logic [VW-1:0] mn;
      logic [VW:0]   ent;
      logic          idl;
      logic          stb;
      logic          exp_v;
      int            d;
      stb = rstn && (m_phase == PER - 1) && !gvt_freeze;
      mn  = ref_min();
      idl = (lvt_valid == '0);
      @(posedge clk);
      edge_k++;
      if (rstn && !gvt_freeze) m_phase = (m_phase + 1) % PER;
      exp_v = 1'b0;
      if (due_q.size() > 0 && due_q[0] == edge_k) begin
         ent   = exp_q.pop_front();
         d     = due_q.pop_front();
         exp_v = 1'b1;
         if (ent[VW-1:0] != '1 && ent[VW-1:0] > m_gvt) m_gvt = ent[VW-1:0];
         if (ent[VW]) m_streak++;
         else m_streak = 0;
         if (m_streak >= 2) m_done = 1'b1;
      end
      if (stb) begin
         exp_q.push_back({idl, mn});
         due_q.push_back(edge_k + LAT);
      end
      #1;
      if (gvt_valid === 1'b1) pulses++;
      check("gvt_valid", {63'd0, gvt_valid}, {63'd0, exp_v});
      check("gvt", gvt, m_gvt);
      check("all_idle", {63'd0, all_idle}, {63'd0, m_done});
   endtask

   task automatic do_reset();
      #1;
      rstn = 1'b0;
      #1;
      check("rst_gvt", gvt, '0);
      check("rst_gvt_valid", {63'd0, gvt_valid}, '0);
      check("rst_all_idle", {63'd0, all_idle}, '0);
      exp_q.delete();
      due_q.delete();
      m_gvt    = '0;
      m_streak = 0;
      m_done   = 1'b0;
      m_phase  = 0;
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   initial begin
      int first;
      int p0;
      int steps;

      // Reset state, with the first sample's inputs already applied.
      set_tile(0, 40, 0);
      set_tile(1, 10, 0);
      set_tile(2, 25, 0);
      set_tile(3, 99, 0);
      lvt_valid = 4'b1111;
      @(posedge clk);
      #1;
      check("reset_gvt", gvt, '0);
      check("reset_gvt_valid", {63'd0, gvt_valid}, '0);
      check("reset_all_idle", {63'd0, all_idle}, '0);
      @(posedge clk);
      #1;
      rstn = 1'b1;

      // First publish latency: strobe at edge 32, gvt_valid at edge 35.
      first = -1;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (gvt_valid === 1'b1 && first < 0) first = k;
      end
      check("first_pulse_edge", 64'(first), 64'd35);
      check("first_gvt", gvt, {32'd10, 32'd0});
      p0 = pulses;
      repeat (PER) tick();
      check("period_pulses", 64'(pulses - p0), 64'd1);

      // Lower minimum is ignored; pulses continue.
      set_tile(1, 5, 0);
      p0 = pulses;
      repeat (2 * PER) tick();
      check("hold_gvt", gvt, {32'd10, 32'd0});
      check("hold_pulses", 64'(pulses - p0), 64'd2);

      // Only valid tiles count.
      lvt_valid = 4'b0100;
      set_tile(0, 1, 1);
      set_tile(1, 1, 1);
      set_tile(2, 7, 0);
      set_tile(3, 1, 1);
      repeat (40) tick();
      check("masked_low_gvt", gvt, {32'd10, 32'd0});
      set_tile(2, 30, 5);
      repeat (40) tick();
      check("masked_gvt", gvt, {32'd30, 32'd5});

      // Two idle periods terminate; flag is sticky.
      lvt_valid = 4'b0000;
      repeat (70) tick();
      check("idle_all_idle", {63'd0, all_idle}, 64'd1);
      check("idle_gvt", gvt, {32'd30, 32'd5});
      lvt_valid = 4'b1111;
      for (int t = 0; t < N; t++) set_tile(t, 50 + t, 0);
      repeat (40) tick();
      check("sticky_all_idle", {63'd0, all_idle}, 64'd1);
      check("resume_gvt", gvt, {32'd50, 32'd0});

      // Freeze: in-flight samples may drain, then no more publishes.
      gvt_freeze = 1'b1;
      repeat (5) tick();
      p0 = pulses;
      repeat (95) tick();
      check("freeze_pulses", 64'(pulses - p0), 64'd0);
      gvt_freeze = 1'b0;
      repeat (40) tick();

      // Reset one cycle after a strobe discards the in-flight sample.
      steps = 0;
      while (due_q.size() == 0 && steps < 2 * PER) begin
         tick();
         steps++;
      end
      check("strobe_found", 64'(due_q.size()), 64'd1);
      tick();
      do_reset();
      lvt_valid = 4'b0011;
      set_tile(0, 8, 3);
      set_tile(1, 8, 2);
      p0 = pulses;
      repeat (PER - 1) tick();
      check("post_reset_pulses", 64'(pulses - p0), 64'd0);
      repeat (9) tick();
      check("tie_gvt", gvt, {32'd8, 32'd2});

      // Randomized traffic with idle gaps and freezes.
      for (int s = 0; s < 30; s++) begin
         for (int t = 0; t < N; t++) set_tile(t, 20 + 8 * s + $urandom_range(0, 20), $urandom_range(0, 3));
         lvt_valid  = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
         gvt_freeze = ($urandom_range(0, 6) == 0);
         repeat ($urandom_range(5, 60)) tick();
      end
      gvt_freeze = 1'b0;
      repeat (2 * PER) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
